// File: rtl/reg_pkg.sv
// Shared constants, width helper and address/data typedefs for the register file.
package reg_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_AW = clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] reg_word_t;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy scoreboard: per-register pending bits, busy counter and busy lookup for both read ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back/issue into busy1/busy2.
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = clog2(NREGS),
    parameter int CW    = clog2(NREGS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_vld,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_vld,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          busy1,
    output logic          busy2,
    output logic [CW-1:0] busy_cnt
);
    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             inc, dec;

    always_comb begin
        busy_d = busy_q;
        if (clr_vld) busy_d[clr_addr] = 1'b0;
        if (set_vld) busy_d[set_addr] = 1'b1;
    end

    // Count transitions rather than events so the counter can never drift.
    always_comb begin
        inc   = set_vld && !busy_q[set_addr];
        dec   = clr_vld && busy_q[clr_addr] && !(set_vld && set_addr == clr_addr);
        cnt_d = cnt_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        busy1 = (clr_vld && clr_addr == rs1_addr) ? (set_vld && set_addr == rs1_addr) : busy_q[rs1_addr];
        busy2 = (clr_vld && clr_addr == rs2_addr) ? (set_vld && set_addr == rs2_addr) : busy_q[rs2_addr];
    end
`else
    always_comb begin
        busy1 = busy_q[rs1_addr];
        busy2 = busy_q[rs2_addr];
    end
`endif

    assign busy_cnt = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with optional zero register and busy scoreboard.
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding on both read ports.
module reg_file_sb
    import reg_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [AW-1:0]              rd_data,
    input  logic [XLEN-1:0]            write_data,
    input  logic [AW-1:0]              rs1_data,
    input  logic [AW-1:0]              rs2_data,
    output logic [XLEN-1:0]            read_data1,
    output logic [XLEN-1:0]            read_data2,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_rd,
    output logic                       busy1,
    output logic                       busy2,
    output logic [clog2(NREGS+1)-1:0]  busy_cnt
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_en;
    logic            iss_en;

    assign wr_en  = enable && !((ZERO_REG != 0) && rd_data == '0);
    assign iss_en = issue_valid && !((ZERO_REG != 0) && issue_rd == '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[rd_data] = write_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        read_data1 = (wr_en && rd_data == rs1_data) ? write_data : regs_q[rs1_data];
        read_data2 = (wr_en && rd_data == rs2_data) ? write_data : regs_q[rs2_data];
    end
`else
    always_comb begin
        read_data1 = regs_q[rs1_data];
        read_data2 = regs_q[rs2_data];
    end
`endif

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (clog2(NREGS + 1))
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_vld  (iss_en),
        .set_addr (issue_rd),
        .clr_vld  (wr_en),
        .clr_addr (rd_data),
        .rs1_addr (rs1_data),
        .rs2_addr (rs2_data),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_cnt (busy_cnt)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default 32x32 instance plus a 64-bit x 16 instance.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          failures = 0;

    logic        enable, issue_valid;
    logic [4:0]  rd_data, rs1_data, rs2_data, issue_rd;
    logic [31:0] write_data, read_data1, read_data2;
    logic        busy1, busy2;
    logic [5:0]  busy_cnt;

    logic        w_enable, w_issue_valid;
    logic [3:0]  w_rd, w_rs1, w_rs2, w_issue_rd;
    logic [63:0] w_wdata, w_rdata1, w_rdata2;
    logic        w_busy1, w_busy2;
    logic [4:0]  w_busy_cnt;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .reset(reset), .enable(enable), .rd_data(rd_data),
        .write_data(write_data), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .read_data1(read_data1), .read_data2(read_data2),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16)) dut_w (
        .clk(clk), .reset(reset), .enable(w_enable), .rd_data(w_rd),
        .write_data(w_wdata), .rs1_data(w_rs1), .rs2_data(w_rs2),
        .read_data1(w_rdata1), .read_data2(w_rdata2),
        .issue_valid(w_issue_valid), .issue_rd(w_issue_rd),
        .busy1(w_busy1), .busy2(w_busy2), .busy_cnt(w_busy_cnt)
    );

    // One clock of write-back/issue on the default instance; returns at posedge+1.
    task automatic cyc(input logic en, input logic [4:0] rd, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ird);
        enable = en; rd_data = rd; write_data = wd; issue_valid = iv; issue_rd = ird;
        @(posedge clk); #1;
        enable = 1'b0; issue_valid = 1'b0;
    endtask

    task automatic wcyc(input logic en, input logic [3:0] rd, input logic [63:0] wd,
                        input logic iv, input logic [3:0] ird);
        w_enable = en; w_rd = rd; w_wdata = wd; w_issue_valid = iv; w_issue_rd = ird;
        @(posedge clk); #1;
        w_enable = 1'b0; w_issue_valid = 1'b0;
    endtask

    task automatic test_reset;
        rs1_data = 5'd3; rs2_data = 5'd17;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin failures++;
            $display("FAIL reset_read rd1=%h rd2=%h expected 0/0", read_data1, read_data2); end
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0 || busy_cnt !== 6'd0) begin failures++;
            $display("FAIL reset_busy b1=%b b2=%b cnt=%0d expected 0/0/0", busy1, busy2, busy_cnt); end
        reset = 1'b0;
        @(posedge clk); #1;
        cyc(1'b1, 5'd1, 32'hDEAD, 1'b0, 5'd0);
        rs1_data = 5'd1; #1;
        checks++; if (read_data1 !== 32'h0000DEAD) begin failures++;
            $display("FAIL write_x1 got=%h expected 0000dead", read_data1); end
    endtask

    task automatic test_zero_reg;
        cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        rs1_data = 5'd0; #1;
        checks++; if (read_data1 !== 32'h0) begin failures++;
            $display("FAIL zero_write got=%h expected 0", read_data1); end
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        checks++; if (busy1 !== 1'b0 || busy_cnt !== 6'd0) begin failures++;
            $display("FAIL zero_issue b1=%b cnt=%0d expected 0/0", busy1, busy_cnt); end
    endtask

    task automatic test_busy;
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
        rs1_data = 5'd5; rs2_data = 5'd6; #1;
        checks++; if (busy_cnt !== 6'd2 || busy1 !== 1'b1 || busy2 !== 1'b1) begin failures++;
            $display("FAIL issue_two cnt=%0d b1=%b b2=%b expected 2/1/1", busy_cnt, busy1, busy2); end
        cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b1 || busy_cnt !== 6'd1) begin failures++;
            $display("FAIL wb_clear b1=%b b2=%b cnt=%0d expected 0/1/1", busy1, busy2, busy_cnt); end
        checks++; if (read_data1 !== 32'h1234) begin failures++;
            $display("FAIL wb_data got=%h expected 00001234", read_data1); end
        cyc(1'b1, 5'd12, 32'h55, 1'b0, 5'd0);
        checks++; if (busy_cnt !== 6'd1) begin failures++;
            $display("FAIL nonbusy_write cnt=%0d expected 1", busy_cnt); end
    endtask

    task automatic test_same_cycle;
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        cyc(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7);
        rs1_data = 5'd7; #1;
        checks++; if (busy1 !== 1'b1 || busy_cnt !== 6'd2 || read_data1 !== 32'hAAAA) begin failures++;
            $display("FAIL set_wins b1=%b cnt=%0d rd=%h expected 1/2/0000aaaa", busy1, busy_cnt, read_data1); end
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd8);
        rs1_data = 5'd8; rs2_data = 5'd9; #1;
        checks++; if (busy1 !== 1'b1 || busy2 !== 1'b0 || busy_cnt !== 6'd3) begin failures++;
            $display("FAIL net_zero b8=%b b9=%b cnt=%0d expected 1/0/3", busy1, busy2, busy_cnt); end
    endtask

    task automatic test_bypass;
        cyc(1'b1, 5'd3, 32'h1111, 1'b0, 5'd0);
        rs1_data = 5'd3;
        enable = 1'b1; rd_data = 5'd3; write_data = 32'hCAFE; #1;
`ifdef REGFILE_BYPASS_EN
        checks++; if (read_data1 !== 32'h0000CAFE) begin failures++;
            $display("FAIL bypass_fwd got=%h expected 0000cafe", read_data1); end
        issue_valid = 1'b1; issue_rd = 5'd3; #1;
        checks++; if (busy1 !== 1'b1) begin failures++;
            $display("FAIL bypass_busy got=%b expected 1", busy1); end
        issue_valid = 1'b0; #1;
`else
        checks++; if (read_data1 !== 32'h1111) begin failures++;
            $display("FAIL no_bypass got=%h expected 00001111", read_data1); end
`endif
        @(posedge clk); #1;
        enable = 1'b0; #1;
        checks++; if (read_data1 !== 32'h0000CAFE) begin failures++;
            $display("FAIL post_edge got=%h expected 0000cafe", read_data1); end
    endtask

    task automatic test_reset_mid;
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd11);
        rs1_data = 5'd4; rs2_data = 5'd1; #1;
        checks++; if (busy_cnt !== 6'd6 || busy1 !== 1'b1 || read_data2 !== 32'hDEAD) begin failures++;
            $display("FAIL pre_reset cnt=%0d b1=%b rd2=%h expected 6/1/0000dead", busy_cnt, busy1, read_data2); end
        #1; reset = 1'b1; #1;
        checks++; if (busy_cnt !== 6'd0 || busy1 !== 1'b0 || read_data2 !== 32'h0) begin failures++;
            $display("FAIL mid_reset cnt=%0d b1=%b rd2=%h expected 0/0/0", busy_cnt, busy1, read_data2); end
    endtask

    task automatic test_wide;
        w_rs1 = 4'd1; w_rs2 = 4'd0; #1;
        checks++; if (w_rdata1 !== 64'h0 || w_busy1 !== 1'b0 || w_busy_cnt !== 5'd0) begin failures++;
            $display("FAIL w_reset rd=%h b=%b cnt=%0d expected 0/0/0", w_rdata1, w_busy1, w_busy_cnt); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        wcyc(1'b1, 4'd1, 64'hDEAD_BEEF_0123_4567, 1'b0, 4'd0);
        wcyc(1'b1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        checks++; if (w_rdata1 !== 64'hDEAD_BEEF_0123_4567 || w_rdata2 !== 64'h0 || w_busy_cnt !== 5'd0) begin failures++;
            $display("FAIL w_write rd1=%h rd0=%h cnt=%0d expected deadbeef01234567/0/0", w_rdata1, w_rdata2, w_busy_cnt); end
        wcyc(1'b0, 4'd0, 64'h0, 1'b1, 4'd5);
        wcyc(1'b0, 4'd0, 64'h0, 1'b1, 4'd6);
        w_rs1 = 4'd5; w_rs2 = 4'd6; #1;
        checks++; if (w_busy_cnt !== 5'd2 || w_busy1 !== 1'b1 || w_busy2 !== 1'b1) begin failures++;
            $display("FAIL w_issue cnt=%0d b1=%b b2=%b expected 2/1/1", w_busy_cnt, w_busy1, w_busy2); end
        wcyc(1'b1, 4'd5, 64'h1234, 1'b0, 4'd0);
        checks++; if (w_busy1 !== 1'b0 || w_busy_cnt !== 5'd1 || w_rdata1 !== 64'h1234) begin failures++;
            $display("FAIL w_wb b1=%b cnt=%0d rd=%h expected 0/1/1234", w_busy1, w_busy_cnt, w_rdata1); end
        wcyc(1'b0, 4'd0, 64'h0, 1'b1, 4'd7);
        wcyc(1'b1, 4'd7, 64'h7, 1'b1, 4'd7);
        w_rs1 = 4'd7; #1;
        checks++; if (w_busy1 !== 1'b1 || w_busy_cnt !== 5'd2) begin failures++;
            $display("FAIL w_set_wins b1=%b cnt=%0d expected 1/2", w_busy1, w_busy_cnt); end
        wcyc(1'b0, 4'd0, 64'h0, 1'b1, 4'd9);
        wcyc(1'b1, 4'd9, 64'h9, 1'b1, 4'd8);
        w_rs1 = 4'd8; w_rs2 = 4'd9; #1;
        checks++; if (w_busy1 !== 1'b1 || w_busy2 !== 1'b0 || w_busy_cnt !== 5'd3) begin failures++;
            $display("FAIL w_net_zero b8=%b b9=%b cnt=%0d expected 1/0/3", w_busy1, w_busy2, w_busy_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0; issue_valid = 1'b0; rd_data = '0; issue_rd = '0;
        write_data = '0; rs1_data = '0; rs2_data = '0;
        w_enable = 1'b0; w_issue_valid = 1'b0; w_rd = '0; w_issue_rd = '0;
        w_wdata = '0; w_rs1 = '0; w_rs2 = '0;
        test_reset;
        test_zero_reg;
        test_busy;
        test_same_cycle;
        test_bypass;
        test_reset_mid;
        test_wide;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
